// File: rtl/switch_ctrl.sv
// Debounced switch input controller on the memory-mapped I/O bus: synchronised, debounced
// levels plus sticky read-to-clear change flags. Define SWITCH_IRQ_EN to add the switchirq output.
module switch_ctrl #(
    parameter int NUM_SW       = 24,
    parameter int DEBOUNCE_CYC = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              switclk,
    input  logic              switrst,
    input  logic              switchcs,
    input  logic              switchread,
    input  logic [2:0]        switchaddr,
    output logic [15:0]       switchrdata,
    input  logic [NUM_SW-1:0] switch_i
`ifdef SWITCH_IRQ_EN
    ,
    output logic              switchirq
`endif
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic [NUM_SW-1:0] r_sync [SYNC_STAGES];
    logic [CNT_W-1:0]  r_cnt  [NUM_SW];
    logic [NUM_SW-1:0] r_stable;
    logic [NUM_SW-1:0] r_chg;
    logic [15:0]       r_rdata;

    logic [NUM_SW-1:0] w_sync;
    logic [NUM_SW-1:0] w_accept;
    logic [NUM_SW-1:0] w_clr;
    logic [NUM_SW-1:0] w_chg_next;
    logic [31:0]       w_stable_ext;
    logic [31:0]       w_chg_ext;
    logic [15:0]       w_rdata;
    logic              w_rd;

    assign w_sync       = r_sync[SYNC_STAGES-1];
    assign w_rd         = switchcs && switchread;
    assign w_stable_ext = 32'(r_stable);
    assign w_chg_ext    = 32'(r_chg);

    // A channel is accepted on the edge its mismatch count reaches DEBOUNCE_CYC.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_accept = '0;
        w_clr    = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            w_accept[i] = (w_sync[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
            if (i < 16) w_clr[i] = w_rd && (switchaddr == 3'h4);
            else        w_clr[i] = w_rd && (switchaddr == 3'h6);
        end
    end

    // A new event wins over a same-edge clear so it is never lost.
    assign w_chg_next = (r_chg & ~w_clr) | w_accept;

    always_comb begin
        w_rdata = 16'h0000;
        case (switchaddr)
            3'h0:    w_rdata = w_stable_ext[15:0];
            3'h2:    w_rdata = w_stable_ext[31:16];
            3'h4:    w_rdata = w_chg_ext[15:0];
            3'h6:    w_rdata = w_chg_ext[31:16];
            default: w_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge switclk) begin
        if (!switrst) begin
            // NOTE: the synchroniser and counter arrays are real flops, not RAM, so they are reset
            // like any other register to discard in-flight debounces.
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
            for (int i = 0; i < NUM_SW; i++)      r_cnt[i]  <= '0;
            r_stable <= '0;
            r_chg    <= '0;
            r_rdata  <= 16'h0000;
        end else begin
            // NOTE: non-blocking assignments let every stage sample its pre-edge neighbour.
            r_sync[0] <= switch_i;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
            for (int i = 0; i < NUM_SW; i++) begin
                if (w_sync[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_stable[i] <= w_sync[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
            r_chg <= w_chg_next;
            if (w_rd) r_rdata <= w_rdata;
        end
    end

    assign switchrdata = r_rdata;

`ifdef SWITCH_IRQ_EN
    logic r_irq;

    always_ff @(posedge switclk) begin
        if (!switrst) r_irq <= 1'b0;
        else          r_irq <= |w_chg_next;
    end

    assign switchirq = r_irq;
`endif

endmodule

// File: tb/tb_switch_ctrl.sv
// Directed bench for switch_ctrl (NUM_SW=24, DEBOUNCE_CYC=4, SYNC_STAGES=2): register
// vector tables plus hand-timed debounce, read-to-clear, collision and reset sequences.
module tb_switch_ctrl;

    logic        clk;
    logic        rst;
    logic        cs;
    logic        rd;
    logic [2:0]  addr;
    logic [15:0] rdata;
    logic [23:0] sw;
`ifdef SWITCH_IRQ_EN
    logic        irq;
`endif

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic        cs;
        logic        rd;
        logic [2:0]  addr;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[21];

    switch_ctrl #(
        .NUM_SW(24),
        .DEBOUNCE_CYC(4),
        .SYNC_STAGES(2)
    ) dut (
        .switclk(clk),
        .switrst(rst),
        .switchcs(cs),
        .switchread(rd),
        .switchaddr(addr),
        .switchrdata(rdata),
        .switch_i(sw)
`ifdef SWITCH_IRQ_EN
        ,
        .switchirq(irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_read(input logic [2:0] a, input logic [15:0] exp, input string name);
        cs   = 1'b1;
        rd   = 1'b1;
        addr = a;
        tick();
        cs = 1'b0;
        rd = 1'b0;
        check(name, {16'h0, rdata}, {16'h0, exp});
    endtask

    task automatic apply_vectors(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            cs   = vecs[i].cs;
            rd   = vecs[i].rd;
            addr = vecs[i].addr;
            tick();
            check($sformatf("vec%0d", i), {16'h0, rdata}, {16'h0, vecs[i].exp});
        end
        cs = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        // Post-reset acceptance of all-high switches (stable lands on the 6th edge).
        vecs[0]  = '{1'b1, 1'b1, 3'h0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b1, 3'h4, 16'h0000};
        vecs[2]  = '{1'b0, 1'b0, 3'h0, 16'h0000};
        vecs[3]  = '{1'b0, 1'b0, 3'h0, 16'h0000};
        vecs[4]  = '{1'b0, 1'b0, 3'h0, 16'h0000};
        vecs[5]  = '{1'b0, 1'b0, 3'h0, 16'h0000};
        vecs[6]  = '{1'b1, 1'b1, 3'h0, 16'hFFFF};
        vecs[7]  = '{1'b1, 1'b1, 3'h2, 16'h00FF};
        vecs[8]  = '{1'b1, 1'b1, 3'h4, 16'hFFFF};
        vecs[9]  = '{1'b1, 1'b1, 3'h6, 16'h00FF};
        vecs[10] = '{1'b1, 1'b1, 3'h4, 16'h0000};
        vecs[11] = '{1'b1, 1'b1, 3'h6, 16'h0000};
        // Decode and strobe qualification with chg = 0x0010 pending.
        vecs[12] = '{1'b1, 1'b1, 3'h0, 16'h001F};
        vecs[13] = '{1'b0, 1'b1, 3'h4, 16'h001F};
        vecs[14] = '{1'b1, 1'b0, 3'h4, 16'h001F};
        vecs[15] = '{1'b1, 1'b1, 3'h1, 16'h0000};
        vecs[16] = '{1'b1, 1'b1, 3'h3, 16'h0000};
        vecs[17] = '{1'b1, 1'b1, 3'h5, 16'h0000};
        vecs[18] = '{1'b1, 1'b1, 3'h7, 16'h0000};
        vecs[19] = '{1'b1, 1'b1, 3'h4, 16'h0010};
        vecs[20] = '{1'b1, 1'b1, 3'h4, 16'h0000};

        rst  = 1'b0;
        cs   = 1'b1;
        rd   = 1'b1;
        addr = 3'h0;
        sw   = 24'hFFFFFF;
        repeat (3) tick();
        check("reset_rdata", {16'h0, rdata}, 32'h0);
        cs  = 1'b0;
        rd  = 1'b0;
        rst = 1'b1;
        apply_vectors(0, 11);

        // Clean restart with all switches low.
        rst = 1'b0;
        sw  = 24'h000000;
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();

        // Bit 3 rises: stable on edge 6, visible in the registered read from edge 7.
        sw[3] = 1'b1;
        cs    = 1'b1;
        rd    = 1'b1;
        addr  = 3'h0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("deb_edge%0d", k), {16'h0, rdata}, (k >= 7) ? 32'h0008 : 32'h0);
        end
        cs = 1'b0;
        rd = 1'b0;
        do_read(3'h4, 16'h0008, "deb_chg");
        do_read(3'h4, 16'h0000, "deb_chg_clr");

        // A 3-cycle glitch is rejected; a 4-cycle pulse is accepted (and later falls back).
        sw[5] = 1'b1;
        repeat (3) tick();
        sw[5] = 1'b0;
        repeat (10) tick();
        do_read(3'h0, 16'h0008, "glitch_stable");
        do_read(3'h4, 16'h0000, "glitch_chg");
        sw[6] = 1'b1;
        repeat (4) tick();
        sw[6] = 1'b0;
        repeat (12) tick();
        do_read(3'h4, 16'h0040, "pulse4_chg");
        do_read(3'h0, 16'h0008, "pulse4_stable");

        // Read-to-clear touches only the addressed word.
        sw[17] = 1'b1;
        sw[1]  = 1'b1;
        repeat (8) tick();
        do_read(3'h6, 16'h0002, "rtc_hi");
        do_read(3'h6, 16'h0000, "rtc_hi_again");
        do_read(3'h4, 16'h0002, "rtc_lo_kept");
        do_read(3'h2, 16'h0002, "stable_hi");

        // Collision: bit 2 accepted on the same edge as the clearing read of chg=0x0001.
        sw[0] = 1'b1;
        repeat (8) tick();
        sw[2] = 1'b1;
        repeat (5) tick();
        do_read(3'h4, 16'h0001, "collide_read");
        do_read(3'h4, 16'h0004, "collide_kept");
        do_read(3'h0, 16'h000F, "collide_stable");

        sw[4] = 1'b1;
        repeat (8) tick();
        apply_vectors(12, 20);

`ifdef SWITCH_IRQ_EN
        check("irq_idle", {31'h0, irq}, 32'h0);
        sw[0] = 1'b0;
        repeat (5) tick();
        check("irq_before", {31'h0, irq}, 32'h0);
        tick();
        check("irq_set", {31'h0, irq}, 32'h1);
        do_read(3'h4, 16'h0001, "irq_chg");
        check("irq_clr", {31'h0, irq}, 32'h0);
        sw[0] = 1'b1;
`endif

        // Mid-debounce reset with a read strobe active: reset wins, counters restart.
        repeat (3) tick();
        do_read(3'h2, 16'h0002, "pre_rst_hi");
        cs   = 1'b1;
        rd   = 1'b1;
        addr = 3'h0;
        rst  = 1'b0;
        tick();
        check("midrst_rdata", {16'h0, rdata}, 32'h0);
`ifdef SWITCH_IRQ_EN
        check("midrst_irq", {31'h0, irq}, 32'h0);
`endif
        rst = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("rst_edge%0d", k), {16'h0, rdata}, (k >= 7) ? 32'h001F : 32'h0);
`ifdef SWITCH_IRQ_EN
            check($sformatf("rst_irq%0d", k), {31'h0, irq}, (k >= 6) ? 32'h1 : 32'h0);
`endif
        end
        cs = 1'b0;
        rd = 1'b0;
        do_read(3'h4, 16'h001F, "rst_chg_lo");
        do_read(3'h6, 16'h0002, "rst_chg_hi");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
